// File: rtl/result_writer_pkg.sv
// result_writer_pkg
//   Shared widths, the packed lane-group type and the writer FSM state
//   encoding for result_writer and its group FIFO.
//   The optional RESULT_WRITER_SAT_EN macro is consumed in result_writer.sv.
package result_writer_pkg;

  localparam int DATA_W = 18;   // ALU lane result width
  localparam int OUT_W  = 16;   // result RAM word width
  localparam int LANES  = 4;    // lanes per ALU group

  // {res1,res2,res3,res4}: res1 sits in the highest lane index
  typedef logic [LANES-1:0][DATA_W-1:0] group_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/result_group_fifo.sv
// result_group_fifo
//   Two-entry FIFO of whole lane groups. A pop frees its entry in the same
//   cycle, so a push into a full FIFO is accepted when it coincides with a pop.
//   Ports:
//     i_clk, i_rst     clock, async active-high reset
//     i_push, i_data   push request and group to store
//     i_pop            pop request (ignored when empty)
//     o_full           two entries held
//     o_head_nxt       head group as it will be after this edge
//     o_empty_nxt      FIFO will be empty after this edge
module result_group_fifo #(
  parameter int W = 72
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_full,
  output logic [W-1:0] o_head_nxt,
  output logic         o_empty_nxt
);

  logic [W-1:0] r_mem [2];
  logic         r_rd;
  logic         r_wr;
  logic [1:0]   r_cnt;

  logic         w_pop;
  logic         w_push;
  logic         w_rd_nxt;
  logic [1:0]   w_cnt_nxt;

  assign w_pop  = i_pop && (r_cnt != 2'd0);
  assign w_push = i_push && ((r_cnt != 2'd2) || w_pop);
  assign o_full = (r_cnt == 2'd2);

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + 2'd1;
      2'b01:   w_cnt_nxt = r_cnt - 2'd1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  assign w_rd_nxt    = w_pop ? ~r_rd : r_rd;
  assign o_empty_nxt = (w_cnt_nxt == 2'd0);

  // Look-ahead head lets the writer register its outputs one edge early.
  always_comb begin
    o_head_nxt = '0;
    if (w_cnt_nxt != 2'd0) begin
      if (w_push && (r_wr == w_rd_nxt)) o_head_nxt = i_data;
      else                              o_head_nxt = r_mem[w_rd_nxt];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd  <= 1'b0;
      r_wr  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) r_wr <= ~r_wr;
      if (w_pop)  r_rd <= ~r_rd;
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/result_writer.sv
// result_writer
//   Captures four-lane ALU result groups, buffers two, and writes them one
//   word per cycle into the result RAM, honouring ram_busy. Pulses wr_done
//   once a frame (closed by frame_done) is fully committed.
//   Optional macro: RESULT_WRITER_SAT_EN -> saturate words to OUT_W bits
//   instead of truncating.
//   Ports:
//     clk, rst                 clock, async active-high reset
//     res_valid, res1..res4    group strobe and lane results
//     frame_done               last group of the frame
//     ram_busy                 RAM refuses a write this cycle
//     ram_we/ram_addr/ram_wdata  RAM write port (registered)
//     wr_done                  frame committed pulse
//     overflow                 sticky group-dropped flag
//     busy                     FIFO non-empty or frame end pending
//
//   state | meaning
//   IDLE  | nothing queued, no write request
//   WRITE | presenting word word_idx of the head group
//   DONE  | frame drained: wr_done pulse, address back to 0
module result_writer #(
  parameter int DATA_W = result_writer_pkg::DATA_W,
  parameter int OUT_W  = result_writer_pkg::OUT_W,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res1,
  input  logic [DATA_W-1:0] res2,
  input  logic [DATA_W-1:0] res3,
  input  logic [DATA_W-1:0] res4,
  input  logic              frame_done,
  input  logic              ram_busy,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [OUT_W-1:0]  ram_wdata,
  output logic              wr_done,
  output logic              overflow,
  output logic              busy
);
  import result_writer_pkg::*;

  localparam logic [1:0] LAST_LANE = 2'(LANES - 1);

  state_e                        r_state;
  state_e                        w_state_nxt;
  logic                          r_pend;
  logic                          r_ovf;
  logic                          r_we;
  logic                          r_done;
  logic                          r_busy;
  logic [1:0]                    r_idx;
  logic [ADDR_W-1:0]             r_addr;
  logic [OUT_W-1:0]              r_wdata;

  logic                          w_full;
  logic                          w_empty_nxt;
  logic [LANES-1:0][DATA_W-1:0]  w_head_nxt;
  logic                          w_commit;
  logic                          w_pop;
  logic                          w_pend_nxt;
  logic [1:0]                    w_idx_nxt;
  logic [ADDR_W-1:0]             w_addr_nxt;
  logic [OUT_W-1:0]              w_wdata_nxt;

  function automatic logic [OUT_W-1:0] conv(input logic [DATA_W-1:0] v);
`ifdef RESULT_WRITER_SAT_EN
    conv = ((v >> OUT_W) != '0) ? '1 : OUT_W'(v);
`else
    conv = OUT_W'(v);
`endif
  endfunction

  result_group_fifo #(.W(LANES * DATA_W)) u_fifo (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_push      (res_valid),
    .i_data      ({res1, res2, res3, res4}),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_head_nxt  (w_head_nxt),
    .o_empty_nxt (w_empty_nxt)
  );

  // ram_busy only gates commits; the request itself comes from a flop.
  assign w_commit   = (r_state == WRITE) && !ram_busy;
  assign w_pop      = w_commit && (r_idx == LAST_LANE);
  assign w_pend_nxt = frame_done || (r_pend && (r_state != DONE));
  assign w_idx_nxt  = w_commit ? r_idx + 2'd1 : r_idx;

  always_comb begin
    w_addr_nxt = r_addr;
    if (r_state == DONE) w_addr_nxt = '0;
    else if (w_commit)   w_addr_nxt = r_addr + 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!w_empty_nxt)    w_state_nxt = WRITE;
        else if (w_pend_nxt) w_state_nxt = DONE;
      end
      WRITE: begin
        if (w_pop && w_empty_nxt) w_state_nxt = w_pend_nxt ? DONE : IDLE;
      end
      DONE: begin
        w_state_nxt = w_empty_nxt ? IDLE : WRITE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // res1 is word 0 and lives in the top lane of the packed group.
  assign w_wdata_nxt = conv(w_head_nxt[LAST_LANE - w_idx_nxt]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pend  <= 1'b0;
      r_ovf   <= 1'b0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_idx   <= 2'd0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_ovf   <= r_ovf || (res_valid && w_full && !w_pop);
      r_we    <= (w_state_nxt == WRITE);
      r_done  <= (w_state_nxt == DONE);
      r_busy  <= !w_empty_nxt || w_pend_nxt;
      r_idx   <= w_idx_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= (w_state_nxt == WRITE) ? w_wdata_nxt : '0;
    end
  end

  assign ram_we    = r_we;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign wr_done   = r_done;
  assign overflow  = r_ovf;
  assign busy      = r_busy;

endmodule
